// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and encoder helper for the K=7 r=1/2 Viterbi decoder
package viterbi_pkg;
    localparam int K       = 7;
    localparam int NSTATES = 64;
    localparam int SOFT_W  = 8;
    localparam int SM_W    = 20;
    localparam int BM_W    = 9;
    localparam int DEPTH   = 64;

    localparam logic [SM_W-1:0] NORM_TH = 20'd262144;
    localparam logic [SM_W-1:0] INIT_SM = 20'd4096;
    localparam logic [K-1:0]    POLY_G1 = 7'b1111001;
    localparam logic [K-1:0]    POLY_G2 = 7'b1011011;

    // Encoder output {c0, c1} for input bit u leaving state s (newest bit in s[5]).
    function automatic logic [1:0] conv_out(input logic [5:0] state, input logic u);
        logic [K-1:0] r;
        r = {u, state};
        return {^(r & POLY_G1), ^(r & POLY_G2)};
    endfunction
endpackage

// File: rtl/viterbi_bmu.sv
// rtl/viterbi_bmu.sv - branch metrics for the four code pairs, indexed by {c0, c1}
module viterbi_bmu
    import viterbi_pkg::*;
(
    input  logic signed [SOFT_W-1:0] i_s0,
    input  logic signed [SOFT_W-1:0] i_s1,
    output logic [3:0][BM_W-1:0]     o_bm
);
    logic [SOFT_W-1:0] w_z0, w_z1, w_o0, w_o1;

    // Flipping the sign bit gives s+128; its complement is 127-s.
    assign w_z0 = {~i_s0[SOFT_W-1], i_s0[SOFT_W-2:0]};
    assign w_z1 = {~i_s1[SOFT_W-1], i_s1[SOFT_W-2:0]};
    assign w_o0 = ~w_z0;
    assign w_o1 = ~w_z1;

    assign o_bm[0] = {1'b0, w_z0} + {1'b0, w_z1};
    assign o_bm[1] = {1'b0, w_z0} + {1'b0, w_o1};
    assign o_bm[2] = {1'b0, w_o0} + {1'b0, w_z1};
    assign o_bm[3] = {1'b0, w_o0} + {1'b0, w_o1};
endmodule

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - soft-decision register-exchange Viterbi decoder, K=7 rate 1/2
module viterbi_decoder
    import viterbi_pkg::*;
(
    input  logic                     clk,
    input  logic                     sys_rst,
    input  logic signed [SOFT_W-1:0] soft_inp,
    input  logic                     valid_in_vit,
    output logic                     ready_in,
    output logic                     vit_desc,
    output logic                     valid_out_vit,
    output logic                     normalization,
    output logic [SM_W-1:0]          sm_0_debug
);
    localparam logic [6:0] CNT_FULL = 7'(DEPTH);

    logic                     r_ready, r_phase, r_desc, r_vout, r_norm;
    logic signed [SOFT_W-1:0] r_s0;
    logic [6:0]               r_cnt;
    logic [SM_W-1:0]          r_sm   [NSTATES];
    // Bit DEPTH-1 is only ever read straight off the new survivor, so it is not stored.
    logic [DEPTH-2:0]         r_surv [NSTATES];

    logic [3:0][BM_W-1:0] w_bm;
    logic [SM_W-1:0]      w_sm_new   [NSTATES];
    logic [DEPTH-1:0]     w_surv_new [NSTATES];
    logic [5:0]           w_min_idx;
    logic                 w_norm, w_accept, w_sym;

    assign w_accept = valid_in_vit & r_ready;
    assign w_sym    = w_accept & r_phase;

    viterbi_bmu u_bmu (
        .i_s0 (r_s0),
        .i_s1 (soft_inp),
        .o_bm (w_bm)
    );

    for (genvar n = 0; n < NSTATES; n++) begin : g_acs
        localparam logic [5:0] NS = 6'(n);
        localparam logic [5:0] P0 = {NS[4:0], 1'b0};
        localparam logic [5:0] P1 = {NS[4:0], 1'b1};
        localparam logic       U  = NS[5];
        localparam logic [1:0] CA = conv_out(P0, U);
        localparam logic [1:0] CB = conv_out(P1, U);

        logic [SM_W-1:0] w_cand0, w_cand1;
        logic            w_pick1;

        assign w_cand0 = r_sm[P0] + {{(SM_W-BM_W){1'b0}}, w_bm[CA]};
        assign w_cand1 = r_sm[P1] + {{(SM_W-BM_W){1'b0}}, w_bm[CB]};
        assign w_pick1 = w_cand1 < w_cand0;
        assign w_sm_new[n]   = w_pick1 ? w_cand1 : w_cand0;
        assign w_surv_new[n] = {w_pick1 ? r_surv[P1] : r_surv[P0], U};
    end

    // Pairwise tree; the left (lower-index) side wins ties at every level.
    function automatic logic [5:0] min_index(input logic [SM_W-1:0] v [NSTATES]);
        logic [SM_W-1:0] tv [NSTATES];
        logic [5:0]      ti [NSTATES];
        for (int j = 0; j < NSTATES; j++) begin
            tv[j] = v[j];
            ti[j] = 6'(j);
        end
        for (int w = NSTATES / 2; w >= 1; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                if (tv[2*i+1] < tv[2*i]) begin
                    tv[i] = tv[2*i+1];
                    ti[i] = ti[2*i+1];
                end else begin
                    tv[i] = tv[2*i];
                    ti[i] = ti[2*i];
                end
            end
        end
        return ti[0];
    endfunction

    assign w_min_idx = min_index(w_sm_new);
    assign w_norm    = w_sm_new[w_min_idx] >= NORM_TH;

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            r_ready <= 1'b0;
            r_phase <= 1'b0;
            r_s0    <= '0;
            r_cnt   <= '0;
            r_desc  <= 1'b0;
            r_vout  <= 1'b0;
            r_norm  <= 1'b0;
            for (int n = 0; n < NSTATES; n++) begin
                r_sm[n]   <= (n == 0) ? '0 : INIT_SM;
                r_surv[n] <= '0;
            end
        end else begin
            r_ready <= 1'b1;
            r_vout  <= 1'b0;
            r_norm  <= 1'b0;
            if (w_accept) begin
                r_phase <= ~r_phase;
            end
            if (w_accept && !r_phase) begin
                r_s0 <= soft_inp;
            end
            if (w_sym) begin
                for (int n = 0; n < NSTATES; n++) begin
                    r_sm[n]   <= w_norm ? (w_sm_new[n] - NORM_TH) : w_sm_new[n];
                    r_surv[n] <= w_surv_new[n][DEPTH-2:0];
                end
                r_norm <= w_norm;
                if (r_cnt != CNT_FULL) begin
                    r_cnt <= r_cnt + 7'd1;
                end
                if (r_cnt >= CNT_FULL - 7'd1) begin
                    r_vout <= 1'b1;
                    r_desc <= w_surv_new[w_min_idx][DEPTH-1];
                end
            end
        end
    end

    assign ready_in      = r_ready;
    assign vit_desc      = r_desc;
    assign valid_out_vit = r_vout;
    assign normalization = r_norm;
    assign sm_0_debug    = r_sm[0];
endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - directed self-checking bench for viterbi_decoder
module tb_viterbi_decoder;
    logic              clk = 1'b0;
    logic              sys_rst;
    logic signed [7:0] soft_inp;
    logic              valid_in_vit;
    logic              ready_in, vit_desc, valid_out_vit, normalization;
    logic [19:0]       sm_0_debug;

    int errors = 0;
    int checks = 0;

    logic              out_q [$];
    int                sym_cnt, ph, first_pulse_sym, norm_cnt, first_norm_sym;
    logic [19:0]       max_sm0;
    logic              msg    [1000];
    logic [5:0]        tstate [1000];
    logic signed [7:0] tx     [2000];
    logic signed [7:0] txe    [2000];

    always #5 clk = ~clk;

    viterbi_decoder dut (
        .clk           (clk),
        .sys_rst       (sys_rst),
        .soft_inp      (soft_inp),
        .valid_in_vit  (valid_in_vit),
        .ready_in      (ready_in),
        .vit_desc      (vit_desc),
        .valid_out_vit (valid_out_vit),
        .normalization (normalization),
        .sm_0_debug    (sm_0_debug)
    );

    always @(negedge clk) begin
        if (sys_rst) begin
            if (valid_out_vit) begin
                out_q.push_back(vit_desc);
                if (first_pulse_sym < 0) first_pulse_sym = sym_cnt;
            end
            if (normalization) begin
                norm_cnt++;
                if (first_norm_sym < 0) first_norm_sym = sym_cnt;
            end
            if (sm_0_debug > max_sm0) max_sm0 = sm_0_debug;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b0;
        valid_in_vit = 1'b0;
        soft_inp = '0;
        idle(2);
        out_q.delete();
        sym_cnt = 0; ph = 0; first_pulse_sym = -1;
        norm_cnt = 0; first_norm_sym = -1; max_sm0 = '0;
        sys_rst = 1'b1;
        idle(1);
    endtask

    task automatic put(input logic signed [7:0] v);
        soft_inp = v;
        valid_in_vit = 1'b1;
        @(posedge clk);
        #1;
        valid_in_vit = 1'b0;
        soft_inp = 8'($urandom);
        if (ph == 1) begin
            sym_cnt++;
            ph = 0;
        end else begin
            ph = 1;
        end
    endtask

    task automatic compare_msg(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_pulses"}, out_q.size(), 937);
        for (int k = 0; k < 937 && k < out_q.size(); k++)
            if (out_q[k] !== msg[k]) mism++;
        chk({tag, "_bit_mismatches"}, mism, 0);
    endtask

    initial begin
        logic [5:0] st;
        logic [6:0] r;
        int zs, zbad;

        // Encode the reference message; bits 500..509 forced 0 so the true path visits state 0.
        st = '0;
        for (int i = 0; i < 1000; i++) begin
            msg[i] = (i >= 500 && i < 510) ? 1'b0 : 1'($urandom);
            r = {msg[i], st};
            tx[2*i]   = (^(r & 7'b1111001)) ? 8'sd127 : -8'sd128;
            tx[2*i+1] = (^(r & 7'b1011011)) ? 8'sd127 : -8'sd128;
            st = {msg[i], st[5:1]};
            tstate[i] = st;
        end
        for (int j = 0; j < 2000; j++) txe[j] = tx[j];
        for (int i = 5; i < 1000; i += 13) begin
            int j;
            j = 2*i + ((i / 13) % 2);
            txe[j] = (tx[j] == 8'sd127) ? -8'sd128 : 8'sd127;
        end

        // Reset state with random inputs.
        sys_rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            soft_inp = 8'($urandom);
            valid_in_vit = 1'($urandom);
            idle(1);
        end
        chk("rst_ready_in", 32'(ready_in), 0);
        chk("rst_vit_desc", 32'(vit_desc), 0);
        chk("rst_valid_out", 32'(valid_out_vit), 0);
        chk("rst_normalization", 32'(normalization), 0);
        chk("rst_sm0", 32'(sm_0_debug), 0);
        valid_in_vit = 1'b0;
        sys_rst = 1'b1;
        idle(1);
        chk("ready_after_release", 32'(ready_in), 1);

        // All-zero stream.
        do_reset();
        zbad = 0;
        for (int i = 0; i < 100; i++) begin
            put(-8'sd128);
            put(-8'sd128);
            if (sm_0_debug != 0) zbad++;
        end
        idle(3);
        begin
            int ones;
            ones = 0;
            foreach (out_q[k]) if (out_q[k] !== 1'b0) ones++;
            chk("zero_pulses", out_q.size(), 37);
            chk("zero_first_pulse_sym", first_pulse_sym, 64);
            chk("zero_nonzero_bits", ones, 0);
        end
        chk("zero_sm0_nonzero", zbad, 0);
        chk("zero_norm_count", norm_cnt, 0);

        // Noiseless message.
        do_reset();
        zs = 0; zbad = 0;
        for (int i = 0; i < 1000; i++) begin
            put(tx[2*i]);
            put(tx[2*i+1]);
            if (tstate[i] == 6'd0) begin
                zs++;
                if (sm_0_debug != 0) zbad++;
            end
        end
        idle(3);
        compare_msg("clean");
        chk("clean_sm0_on_true_path", zbad, 0);
        chk("clean_state0_visited", 32'(zs > 0), 1);

        // Sparse sign flips.
        do_reset();
        for (int j = 0; j < 2000; j++) put(txe[j]);
        idle(3);
        compare_msg("errs");

        // Random valid gaps, including inside a pair.
        do_reset();
        for (int j = 0; j < 2000; j++) begin
            put(tx[j]);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        compare_msg("gaps");

        // Renormalisation with uninformative samples.
        do_reset();
        for (int j = 0; j < 2200; j++) put(8'sd0);
        idle(3);
        chk("norm_fired", 32'(norm_cnt >= 1), 1);
        chk("norm_first_sym_near_1028", 32'(first_norm_sym >= 1020 && first_norm_sym <= 1040), 1);
        chk("norm_sm0_below_2p19", 32'(max_sm0 < 20'h80000), 1);
        chk("norm_pulses", out_q.size(), 1037);

        // Asynchronous reset mid-stream, between clock edges.
        for (int j = 0; j < 7; j++) put(8'sd50);
        valid_in_vit = 1'b1;
        #2;
        sys_rst = 1'b0;
        #1;
        chk("midrst_sm0", 32'(sm_0_debug), 0);
        chk("midrst_ready_in", 32'(ready_in), 0);
        chk("midrst_valid_out", 32'(valid_out_vit), 0);
        chk("midrst_vit_desc", 32'(vit_desc), 0);
        valid_in_vit = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
